lzc_tree: RTL and testbench



---
 rtl/lzc_tree.sv | 77 +++++++
 tb/tb_lzc_tree.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lzc_tree.sv
// First-set-bit locator: returns the trailing (MODE=0) or leading (MODE=1) zero count and
// flags an all-zero input. The outputs are combinational, or registered when REG_OUT=1.
module lzc_tree #(
  parameter int unsigned WIDTH   = 2,
  parameter bit          MODE    = 1'b0,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [WIDTH-1:0]                                 in_i,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]     cnt_o,
  output logic                                             empty_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned NP    = 1 << CNT_W;

  if (WIDTH == 0) begin : g_width_chk
    $error("lzc_tree: WIDTH must be >= 1");
  end

  logic [NP-1:0]    scan;
  logic             tree_vld [NP];
  logic [CNT_W-1:0] tree_idx [NP];
  logic [CNT_W-1:0] cnt_c;
  logic             empty_c;

  // Leading-zero mode reverses the input, so the tree always prefers the lower half.
  // The padding bits sit above WIDTH, at the far end of the scan.
  always_comb begin
    scan = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      scan[i] = MODE ? in_i[int'(WIDTH) - 1 - i] : in_i[i];
    end
  end

  // In-place log2 reduction. Each level halves the node count, and a node that picks
  // its upper child sets the new index MSB for that level.
  always_comb begin
    for (int n = 0; n < int'(NP); n++) begin
      tree_vld[n] = scan[n];
      tree_idx[n] = '0;
    end
    for (int l = 0; l < int'(CNT_W); l++) begin
      for (int n = 0; n < int'(NP >> (l + 1)); n++) begin
        if (tree_vld[2*n]) begin
          tree_idx[n] = tree_idx[2*n];
        end else begin
          tree_idx[n] = tree_idx[2*n+1] | (CNT_W'(1) << l);
        end
        tree_vld[n] = tree_vld[2*n] | tree_vld[2*n+1];
      end
    end
  end

  // With no bit set, the root index points into the padding, so it is forced to zero.
  assign cnt_c   = tree_vld[0] ? tree_idx[0] : '0;
  assign empty_c = ~tree_vld[0];

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_o   <= '0;
        empty_o <= 1'b1;
      end else begin
        cnt_o   <= cnt_c;
        empty_o <= empty_c;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign cnt_o   = cnt_c;
    assign empty_o = empty_c;
  end

endmodule

// File: tb/tb_lzc_tree.sv
// Scoreboard bench for lzc_tree. It covers several WIDTH and MODE builds and one registered build.
// Expectations are queued at stimulus time, and a negedge monitor compares them.
module tb_lzc_tree;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] vec;
  logic [11:0] emp;
  logic [0:0]  c_w1, c_w2m0, c_w2m1;
  logic [1:0]  c_w3m0, c_w3m1;
  logic [2:0]  c_w5m0, c_w5m1, c_w8m0, c_w8m1, c_w8r;
  logic [4:0]  c_w32m0, c_w32m1;

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         due;
    logic [4:0] cnt;
    logic       emp;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  lzc_tree #(.WIDTH(1),  .MODE(1'b0), .REG_OUT(1'b0)) u_w1   (.clk_i(clk), .rst_i(rst), .in_i(vec[0:0]),  .cnt_o(c_w1),    .empty_o(emp[0]));
  lzc_tree #(.WIDTH(2),  .MODE(1'b0), .REG_OUT(1'b0)) u_w2m0 (.clk_i(clk), .rst_i(rst), .in_i(vec[1:0]),  .cnt_o(c_w2m0),  .empty_o(emp[1]));
  lzc_tree #(.WIDTH(2),  .MODE(1'b1), .REG_OUT(1'b0)) u_w2m1 (.clk_i(clk), .rst_i(rst), .in_i(vec[1:0]),  .cnt_o(c_w2m1),  .empty_o(emp[2]));
  lzc_tree #(.WIDTH(3),  .MODE(1'b0), .REG_OUT(1'b0)) u_w3m0 (.clk_i(clk), .rst_i(rst), .in_i(vec[2:0]),  .cnt_o(c_w3m0),  .empty_o(emp[3]));
  lzc_tree #(.WIDTH(3),  .MODE(1'b1), .REG_OUT(1'b0)) u_w3m1 (.clk_i(clk), .rst_i(rst), .in_i(vec[2:0]),  .cnt_o(c_w3m1),  .empty_o(emp[4]));
  lzc_tree #(.WIDTH(5),  .MODE(1'b0), .REG_OUT(1'b0)) u_w5m0 (.clk_i(clk), .rst_i(rst), .in_i(vec[4:0]),  .cnt_o(c_w5m0),  .empty_o(emp[5]));
  lzc_tree #(.WIDTH(5),  .MODE(1'b1), .REG_OUT(1'b0)) u_w5m1 (.clk_i(clk), .rst_i(rst), .in_i(vec[4:0]),  .cnt_o(c_w5m1),  .empty_o(emp[6]));
  lzc_tree #(.WIDTH(8),  .MODE(1'b0), .REG_OUT(1'b0)) u_w8m0 (.clk_i(clk), .rst_i(rst), .in_i(vec[7:0]),  .cnt_o(c_w8m0),  .empty_o(emp[7]));
  lzc_tree #(.WIDTH(8),  .MODE(1'b1), .REG_OUT(1'b0)) u_w8m1 (.clk_i(clk), .rst_i(rst), .in_i(vec[7:0]),  .cnt_o(c_w8m1),  .empty_o(emp[8]));
  lzc_tree #(.WIDTH(32), .MODE(1'b0), .REG_OUT(1'b0)) u_w32m0(.clk_i(clk), .rst_i(rst), .in_i(vec[31:0]), .cnt_o(c_w32m0), .empty_o(emp[9]));
  lzc_tree #(.WIDTH(32), .MODE(1'b1), .REG_OUT(1'b0)) u_w32m1(.clk_i(clk), .rst_i(rst), .in_i(vec[31:0]), .cnt_o(c_w32m1), .empty_o(emp[10]));
  lzc_tree #(.WIDTH(8),  .MODE(1'b0), .REG_OUT(1'b1)) u_w8r  (.clk_i(clk), .rst_i(rst), .in_i(vec[7:0]),  .cnt_o(c_w8r),   .empty_o(emp[11]));

  function automatic int width_of(input int id);
    case (id)
      0:         return 1;
      1, 2:      return 2;
      3, 4:      return 3;
      5, 6:      return 5;
      7, 8, 11:  return 8;
      default:   return 32;
    endcase
  endfunction

  function automatic bit mode_of(input int id);
    return (id == 2 || id == 4 || id == 6 || id == 8 || id == 10);
  endfunction

  function automatic string name_of(input int id);
    case (id)
      0:  return "w1";
      1:  return "w2_tz";
      2:  return "w2_lz";
      3:  return "w3_tz";
      4:  return "w3_lz";
      5:  return "w5_tz";
      6:  return "w5_lz";
      7:  return "w8_tz";
      8:  return "w8_lz";
      9:  return "w32_tz";
      10: return "w32_lz";
      default: return "w8_reg";
    endcase
  endfunction

  function automatic logic [4:0] actual_cnt(input int id);
    case (id)
      0:  return 5'(c_w1);
      1:  return 5'(c_w2m0);
      2:  return 5'(c_w2m1);
      3:  return 5'(c_w3m0);
      4:  return 5'(c_w3m1);
      5:  return 5'(c_w5m0);
      6:  return 5'(c_w5m1);
      7:  return 5'(c_w8m0);
      8:  return 5'(c_w8m1);
      9:  return c_w32m0;
      10: return c_w32m1;
      default: return 5'(c_w8r);
    endcase
  endfunction

  // Reference: scan for the first set bit inside the active width.
  function automatic logic [4:0] ref_cnt(input logic [31:0] v, input int w, input bit m);
    logic [4:0] r;
    r = '0;
    if (!m) begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) r = 5'(i);
    end else begin
      for (int i = 0; i < w; i++) if (v[i]) r = 5'(w - 1 - i);
    end
    return r;
  endfunction

  function automatic logic ref_emp(input logic [31:0] v, input int w);
    logic e;
    e = 1'b1;
    for (int i = 0; i < w; i++) if (v[i]) e = 1'b0;
    return e;
  endfunction

  task automatic apply(input logic [31:0] v, input logic r);
    @(posedge clk);
    #1;
    vec = v;
    rst = r;
  endtask

  task automatic exp_c(input int id, input logic [4:0] c, input logic e);
    exp_t x;
    x.id = id; x.due = cyc; x.cnt = c; x.emp = e;
    comb_q.push_back(x);
  endtask

  task automatic exp_r(input logic [4:0] c, input logic e);
    exp_t x;
    x.id = 11; x.due = cyc + 1; x.cnt = c; x.emp = e;
    reg_q.push_back(x);
  endtask

  task automatic exp_model();
    for (int id = 0; id < 11; id++) begin
      exp_c(id, ref_cnt(vec, width_of(id), mode_of(id)), ref_emp(vec, width_of(id)));
    end
    exp_r(ref_cnt(vec, 8, 1'b0), ref_emp(vec, 8));
  endtask

  task automatic check(input exp_t x);
    logic [4:0] a_cnt;
    logic       a_emp;
    a_cnt = actual_cnt(x.id);
    a_emp = emp[x.id];
    checks++;
    if (x.due != cyc) begin
      $display("FAIL %s stale entry: due cycle %0d, checked at cycle %0d", name_of(x.id), x.due, cyc);
    end else if (a_cnt !== x.cnt || a_emp !== x.emp) begin
      $display("FAIL %s cycle %0d: got cnt=%0d empty=%b, expected cnt=%0d empty=%b",
               name_of(x.id), cyc, a_cnt, a_emp, x.cnt, x.emp);
    end else begin
      passes++;
    end
  endtask

  // Monitor: retire every expectation that is due in the current cycle.
  always @(negedge clk) begin
    while (comb_q.size() > 0 && comb_q[0].due <= cyc) check(comb_q.pop_front());
    while (reg_q.size() > 0 && reg_q[0].due <= cyc) check(reg_q.pop_front());
  end

  initial begin
    logic [31:0] r1, r2, r3;
    rst = 1'b1;
    vec = '0;

    apply(32'h00, 1'b1); exp_r(5'd0, 1'b1);
    apply(32'h28, 1'b1); exp_c(7, 5'd3, 1'b0); exp_c(8, 5'd2, 1'b0); exp_r(5'd0, 1'b1);
    apply(32'h80, 1'b1); exp_c(7, 5'd7, 1'b0); exp_c(8, 5'd0, 1'b0);
    apply(32'h01, 1'b1); exp_c(7, 5'd0, 1'b0); exp_c(8, 5'd7, 1'b0);
    apply(32'hFF, 1'b1); exp_c(7, 5'd0, 1'b0); exp_c(8, 5'd0, 1'b0);
    apply(32'h00, 1'b1); exp_c(7, 5'd0, 1'b1); exp_c(8, 5'd0, 1'b1);
                         exp_c(5, 5'd0, 1'b1); exp_c(0, 5'd0, 1'b1);
    apply(32'h10, 1'b1); exp_c(5, 5'd4, 1'b0); exp_c(6, 5'd0, 1'b0); exp_c(0, 5'd0, 1'b1);
    apply(32'h01, 1'b1); exp_c(6, 5'd4, 1'b0); exp_c(5, 5'd0, 1'b0); exp_c(0, 5'd0, 1'b0);

    // Registered build: reset, release, then a reset pulse in the middle of the stream
    apply(32'h00, 1'b1); exp_r(5'd0, 1'b1);
    apply(32'h10, 1'b0); exp_r(5'd4, 1'b0);
    apply(32'h80, 1'b0); exp_r(5'd7, 1'b0);
    apply(32'h01, 1'b1); exp_r(5'd0, 1'b1);
    apply(32'h01, 1'b0); exp_r(5'd0, 1'b0);
    apply(32'h28, 1'b0); exp_r(5'd3, 1'b0);

    for (int k = 0; k < 256; k++) begin
      r1 = $urandom();
      apply({r1[31:8], 8'(k)}, 1'b0);
      exp_model();
    end
    for (int i = 0; i < 32; i++) begin
      apply(32'h1 << i, 1'b0);
      exp_model();
    end
    for (int i = 0; i < 64; i++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      apply(r1 & r2 & r3, 1'b0);
      exp_model();
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (comb_q.size() + reg_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations never checked, expected 0", comb_q.size() + reg_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
